// File: rtl/uart_host_pkg.sv
// Shared types and helpers for the host-side UART transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Cycles per serial bit; truncating divide so the line runs slightly fast
    // rather than slow when CLK_HZ is not an exact multiple of BAUD.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_host_tx_if.sv
// Byte-write handshake into the UART transmitter FIFO.
// Latency: n/a (signal bundle only).
// Backpressure: WR_READY low means the FIFO is full and the byte is not taken.
interface uart_host_tx_if;
    import uart_host_pkg::*;

    logic [DATA_BITS-1:0] WR_DATA;
    logic                 WR_VALID;
    logic                 WR_READY;

    modport master (
        output WR_DATA,
        output WR_VALID,
        input  WR_READY
    );

    modport slave (
        input  WR_DATA,
        input  WR_VALID,
        output WR_READY
    );

endinterface

// File: rtl/uart_host_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full stays set during a same-cycle pop.
module uart_host_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_host_tx.sv
// UART transmitter (8N1, LSB first) fed from a byte FIFO; optional even parity via `UART_TX_PARITY_EN.
// Latency: byte accepted at edge N into an idle, empty transmitter -> UART_TXD falls at edge N+2.
// Backpressure: WR_READY drops while the FIFO holds FIFO_DEPTH bytes; frames chain back-to-back with no idle gap.
module uart_host_tx
    import uart_host_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        XCLK,
    input  logic                        XRES,
    uart_host_tx_if.slave               wr,
    output logic                        UART_TXD,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 txd_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    uart_host_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (XCLK),
        .rst       (XRES),
        .push      (wr.WR_VALID),
        .push_data (wr.WR_DATA),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (LEVEL),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr.WR_READY = !fifo_full;
    assign BUSY        = (state != IDLE) || (LEVEL != '0);
    assign bit_end     = (cnt == CNT_LAST);

    // State, baud counter and bit index registers.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Next-state logic: each state/bit lasts BAUD_DIV cycles, counter restarts on every change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? '0 : cnt + 1'b1;
        bit_nxt   = bit_idx;
        fifo_pop  = 1'b0;
        txd_nxt   = 1'b1;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                bit_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                txd_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                txd_nxt = shreg[0];
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_nxt = par_bit;
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // Shift register load/shift and the registered line driver; the line follows state by one cycle.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            shreg    <= '0;
            UART_TXD <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            UART_TXD <= txd_nxt;
            if (fifo_pop) begin
                shreg   <= fifo_head;
`ifdef UART_TX_PARITY_EN
                par_bit <= ^fifo_head;
`endif
            end else if (state == DATA && bit_end) begin
                shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx: table of single-byte frames plus back-to-back, full and reset cases.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_host_tx;
    import uart_host_pkg::*;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame_np;   // bit i = i-th bit on the line, 8N1
        logic [10:0] frame_p;    // bit i = i-th bit on the line, with even parity
    } vec_t;

    logic       XCLK = 1'b0;
    logic       XRES;
    logic       UART_TXD;
    logic       BUSY;
    logic [2:0] LEVEL;

    int n_pass = 0;
    int n_tot  = 0;

    vec_t       vecs [7];
    logic [7:0] fb   [6];
    logic       mon_en = 1'b0;
    logic [8:0] rx_q [$];
    logic [7:0] rx_b;
    logic       rx_sb;

    uart_host_tx_if wr();

    uart_host_tx #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (4)
    ) dut (
        .XCLK     (XCLK),
        .XRES     (XRES),
        .wr       (wr),
        .UART_TXD (UART_TXD),
        .BUSY     (BUSY),
        .LEVEL    (LEVEL)
    );

    always #5 XCLK = ~XCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [10:0] exp_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return v.frame_p;
`else
        return {1'b0, v.frame_np};
`endif
    endfunction

    // Called at the negedge of the first start-bit cycle; returns at the last stop-bit cycle.
    task automatic expect_frame(input logic [10:0] frame, input string name, output logic busy_late);
        int nbad;
        nbad      = 0;
        busy_late = 1'b0;
        for (int k = 0; k < NB*BD; k++) begin
            if (k > 0) @(negedge XCLK);
            if (UART_TXD !== frame[k/BD]) nbad++;
            if (k == NB*BD-2) busy_late = BUSY;
            if (k % BD == BD-1) begin
                chk($sformatf("%s bit%0d bad cycles", name, k/BD), nbad, 0);
                nbad = 0;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (BUSY && n < max_cyc) begin
            @(negedge XCLK);
            n++;
        end
        chk(name, BUSY, 1'b0);
    endtask

    // Line receiver sampling mid-bit; used only where byte order matters.
    initial begin
        forever begin
            @(negedge XCLK);
            if (mon_en && UART_TXD == 1'b0) begin
                repeat (BD/2) @(negedge XCLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge XCLK);
                    rx_b[i] = UART_TXD;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BD) @(negedge XCLK);
`endif
                repeat (BD) @(negedge XCLK);
                rx_sb = UART_TXD;
                rx_q.push_back({rx_sb, rx_b});
            end
        end
    end

    initial begin
        logic bl;
        int   acc;
        int   nzero;

        vecs[0] = '{8'hA5, 10'b1101001010, 11'b10101001010};
        vecs[1] = '{8'h00, 10'b1000000000, 11'b10000000000};
        vecs[2] = '{8'hFF, 10'b1111111110, 11'b10111111110};
        vecs[3] = '{8'h07, 10'b1000001110, 11'b11000001110};
        vecs[4] = '{8'h3C, 10'b1001111000, 11'b10001111000};
        vecs[5] = '{8'h81, 10'b1100000010, 11'b10100000010};
        vecs[6] = '{8'h01, 10'b1000000010, 11'b11000000010};
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
        fb[3] = 8'h44; fb[4] = 8'h55; fb[5] = 8'h66;

        // Reset
        XRES        = 1'b1;
        wr.WR_VALID = 1'b0;
        wr.WR_DATA  = 8'h00;
        repeat (3) @(posedge XCLK);
        @(negedge XCLK);
        XRES = 1'b0;
        chk("reset txd",   UART_TXD,    1'b1);
        chk("reset ready", wr.WR_READY, 1'b1);
        chk("reset level", LEVEL,       3'd0);
        chk("reset busy",  BUSY,        1'b0);

        // Single-byte frames
        for (int v = 0; v < 7; v++) begin
            @(negedge XCLK);
            wr.WR_VALID = 1'b1;
            wr.WR_DATA  = vecs[v].data;
            chk($sformatf("v%0d ready", v), wr.WR_READY, 1'b1);
            @(negedge XCLK);                       // after edge N
            wr.WR_VALID = 1'b0;
            chk($sformatf("v%0d level N", v), LEVEL, 3'd1);
            chk($sformatf("v%0d busy N", v), BUSY, 1'b1);
            chk($sformatf("v%0d txd N", v), UART_TXD, 1'b1);
            @(negedge XCLK);                       // after edge N+1
            chk($sformatf("v%0d txd N+1", v), UART_TXD, 1'b1);
            chk($sformatf("v%0d level N+1", v), LEVEL, 3'd0);
            @(negedge XCLK);                       // after edge N+2: start bit
            expect_frame(exp_frame(vecs[v]), $sformatf("v%0d", v), bl);
            chk($sformatf("v%0d busy before end", v), bl, 1'b1);
            chk($sformatf("v%0d busy after frame", v), BUSY, 1'b0);
            @(negedge XCLK);
            chk($sformatf("v%0d idle txd", v), UART_TXD, 1'b1);
        end

        // Back-to-back 00 then FF
        @(negedge XCLK);
        wr.WR_VALID = 1'b1;
        wr.WR_DATA  = 8'h00;
        @(negedge XCLK);
        wr.WR_DATA  = 8'hFF;
        @(negedge XCLK);
        wr.WR_VALID = 1'b0;
        chk("b2b level", LEVEL, 3'd1);
        @(negedge XCLK);
        expect_frame(exp_frame(vecs[1]), "b2b first", bl);
        chk("b2b busy between", BUSY, 1'b1);
        chk("b2b level between", LEVEL, 3'd0);
        @(negedge XCLK);
        expect_frame(exp_frame(vecs[2]), "b2b second", bl);
        chk("b2b busy end", BUSY, 1'b0);

        // Full FIFO: six consecutive writes, the sixth refused
        rx_q.delete();
        mon_en = 1'b1;
        acc    = 0;
        @(negedge XCLK);
        wr.WR_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr.WR_DATA = fb[i];
            if (i == 4) begin
                chk("full level before 5th", LEVEL, 3'd3);
                chk("full ready before 5th", wr.WR_READY, 1'b1);
            end
            if (i == 5) begin
                chk("full level", LEVEL, 3'd4);
                chk("full ready", wr.WR_READY, 1'b0);
            end
            if (wr.WR_READY) acc++;
            @(negedge XCLK);
        end
        wr.WR_VALID = 1'b0;
        chk("full accepted", acc, 5);
        wait_idle(1000, "full drain");
        repeat (2*BD) @(negedge XCLK);
        mon_en = 1'b0;
        chk("full rx count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk($sformatf("full rx%0d", i), rx_q[i], {1'b1, fb[i]});
        end

        // Reset at frame bit 3 (a zero data bit of 8'h00) with a byte still queued
        @(negedge XCLK);
        wr.WR_VALID = 1'b1;
        wr.WR_DATA  = 8'h00;
        @(negedge XCLK);
        wr.WR_DATA  = 8'hFF;
        @(negedge XCLK);
        wr.WR_VALID = 1'b0;
        @(negedge XCLK);                           // start bit, cycle 0
        repeat (3*BD + BD/2) @(negedge XCLK);
        chk("rst pre txd", UART_TXD, 1'b0);
        chk("rst pre level", LEVEL, 3'd1);
        XRES = 1'b1;
        @(negedge XCLK);
        XRES = 1'b0;
        chk("rst txd", UART_TXD, 1'b1);
        chk("rst level", LEVEL, 3'd0);
        chk("rst busy", BUSY, 1'b0);
        chk("rst ready", wr.WR_READY, 1'b1);
        nzero = 0;
        for (int i = 0; i < 30*BD; i++) begin
            @(negedge XCLK);
            if (UART_TXD !== 1'b1 || BUSY !== 1'b0) nzero++;
        end
        chk("rst quiet cycles", nzero, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
